// File: rtl/polar64_pkg.sv
// Shared types and constants for the polar64 decoder scheduler.
package polar64_pkg;

   localparam int unsigned RX_W        = 64;
   localparam int unsigned DATA_W      = 24;
   localparam int unsigned ID_MAX_W    = 3;
   localparam int unsigned DEC_MAX_LAT = 12;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } sched_state_t;

   // Response payload; id is sized for the largest supported requester count.
   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [DATA_W-1:0]   data;
      logic                ok;
      logic                err;
   } dec_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      logic [IW-1:0] k;
      k     = '0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         k = IW'((32'(ptr) + i) % N);
         if (en && !any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/polar64_decode_sched.sv
// Shares one polar64 decoder between N_REQ requesters: round-robin grant,
// start/done sequencing with a done-timeout, tagged responses and outcome counters.
module polar64_decode_sched
   import polar64_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*64-1:0]      req_rx,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [$clog2(N_REQ)-1:0] resp_id,
   output logic [23:0]              resp_data,
   output logic                     resp_ok,
   output logic                     resp_err,
   output logic                     dec_start,
   output logic [63:0]              dec_rx,
   input  logic                     dec_done,
   input  logic [23:0]              dec_data,
   input  logic                     dec_valid,
   output logic [CNT_W-1:0]         cnt_ok,
   output logic [CNT_W-1:0]         cnt_fail,
   output logic [CNT_W-1:0]         cnt_tmo
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   sched_state_t      state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   job_id;
   logic [RX_W-1:0]   job_rx;
   logic [TMO_W-1:0]  tmo_cnt;
   dec_resp_t         resp_q;

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic [RX_W-1:0]   grant_rx;
   logic              unused_id_hi;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .en    ((state == IDLE) && !rst),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   // Handshake is combinational in IDLE; the grant is already qualified by req_valid.
   assign req_ready = gnt;

   always_comb begin
      grant_rx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) grant_rx = req_rx[RX_W*i +: RX_W];
      end
   end

   assign dec_rx       = job_rx;
   assign resp_id      = resp_q.id[ID_W-1:0];
   assign resp_data    = resp_q.data;
   assign resp_ok      = resp_q.ok;
   assign resp_err     = resp_q.err;
   assign unused_id_hi = ^resp_q.id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         job_id     <= '0;
         job_rx     <= '0;
         tmo_cnt    <= '0;
         resp_q     <= '0;
         resp_valid <= 1'b0;
         dec_start  <= 1'b0;
         cnt_ok     <= '0;
         cnt_fail   <= '0;
         cnt_tmo    <= '0;
      end else begin
         dec_start <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  job_rx    <= grant_rx;
                  job_id    <= gnt_idx;
                  dec_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               // A done in the timeout cycle still counts as a real result.
               if (dec_done) begin
                  resp_q.id   <= ID_MAX_W'(job_id);
                  resp_q.data <= dec_data;
                  resp_q.ok   <= dec_valid;
                  resp_q.err  <= 1'b0;
                  resp_valid  <= 1'b1;
                  state       <= RESP;
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  resp_q.id   <= ID_MAX_W'(job_id);
                  resp_q.data <= '0;
                  resp_q.ok   <= 1'b0;
                  resp_q.err  <= 1'b1;
                  resp_valid  <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  if (resp_q.err) begin
                     if (cnt_tmo != {CNT_W{1'b1}}) cnt_tmo <= cnt_tmo + CNT_W'(1);
                  end else if (resp_q.ok) begin
                     if (cnt_ok != {CNT_W{1'b1}}) cnt_ok <= cnt_ok + CNT_W'(1);
                  end else begin
                     if (cnt_fail != {CNT_W{1'b1}}) cnt_fail <= cnt_fail + CNT_W'(1);
                  end
                  rr_ptr <= (job_id == ID_W'(N_REQ - 1)) ? '0 : job_id + ID_W'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_polar64_decode_sched.sv
// Directed bench for polar64_decode_sched with a latency-programmable decoder stub.
module tb_polar64_decode_sched;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [255:0] req_rx;
   logic         resp_valid;
   logic         resp_ready;
   logic [1:0]   resp_id;
   logic [23:0]  resp_data;
   logic         resp_ok;
   logic         resp_err;
   logic         dec_start;
   logic [63:0]  dec_rx;
   logic         dec_done;
   logic [23:0]  dec_data;
   logic         dec_valid;
   logic [15:0]  cnt_ok;
   logic [15:0]  cnt_fail;
   logic [15:0]  cnt_tmo;

   int total = 0;
   int bad   = 0;

   // Decoder stub: done exactly lat cycles after the start cycle.
   logic [31:0] cyc      = '0;
   logic [31:0] done_cyc = '0;
   logic        pend     = 1'b0;
   int          lat;
   logic        stub_en;
   logic        force_done;

   polar64_decode_sched #(.N_REQ(4), .TIMEOUT(16), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rx     (req_rx),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ok    (resp_ok),
      .resp_err   (resp_err),
      .dec_start  (dec_start),
      .dec_rx     (dec_rx),
      .dec_done   (dec_done),
      .dec_data   (dec_data),
      .dec_valid  (dec_valid),
      .cnt_ok     (cnt_ok),
      .cnt_fail   (cnt_fail),
      .cnt_tmo    (cnt_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (dec_start) begin
         pend     <= 1'b1;
         done_cyc <= cyc + 32'(lat);
      end
   end

   assign dec_done  = (stub_en && pend && (cyc == done_cyc)) || force_done;
   assign dec_data  = dec_rx[23:0] ^ 24'hA5A5A5;
   assign dec_valid = dec_rx[63];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;
      force_done = 1'b0;
      stub_en    = 1'b1;
      lat        = 2;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      req_rx = '0;
      do_reset();
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_err, dec_start, dec_rx} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: ready=%b rv=%b id=%0d data=%h ok=%b err=%b start=%b rx=%h",
                  req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_err, dec_start, dec_rx);
      end
      total++;
      if ({cnt_ok, cnt_fail, cnt_tmo} !== '0) begin
         bad++;
         $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cnt_ok, cnt_fail, cnt_tmo);
      end
      tick();
   endtask

   task automatic test_single;
      do_reset();
      req_rx[128 +: 64] = 64'h8000_0000_0012_3456;
      req_valid = 4'b0100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL single_grant: got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if ({dec_start, req_ready, dec_rx} !== {1'b1, 4'b0000, 64'h8000_0000_0012_3456}) begin
         bad++; $display("FAIL single_issue: start=%b ready=%b rx=%h", dec_start, req_ready, dec_rx);
      end
      repeat (2) begin
         tick();
         @(negedge clk);
         total++;
         if ({resp_valid, dec_start} !== 2'b00) begin
            bad++; $display("FAIL single_wait: rv=%b start=%b want 0 0", resp_valid, dec_start);
         end
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_data, resp_ok, resp_err} !== {1'b1, 2'd2, 24'hB791F3, 1'b1, 1'b0}) begin
         bad++; $display("FAIL single_resp: rv=%b id=%0d data=%h ok=%b err=%b want 1 2 b791f3 1 0",
                         resp_valid, resp_id, resp_data, resp_ok, resp_err);
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp_valid, cnt_ok, cnt_fail, cnt_tmo} !== {1'b0, 16'd1, 16'd0, 16'd0}) begin
         bad++; $display("FAIL single_count: rv=%b cnt=%0d/%0d/%0d want 0 1/0/0",
                         resp_valid, cnt_ok, cnt_fail, cnt_tmo);
      end
   endtask

   task automatic test_all_four;
      logic [23:0] exp_d [4];
      logic [3:0]  gmask;
      int n_g, n_r, last_r;
      exp_d = '{24'hA5A5A5, 24'hB4B4B4, 24'h878787, 24'h969696};
      n_g = 0; n_r = 0; last_r = 0;
      do_reset();
      req_rx[0   +: 64] = 64'h0000_0000_0000_0000;
      req_rx[64  +: 64] = 64'h0000_0001_0011_1111;
      req_rx[128 +: 64] = 64'h0000_0002_0022_2222;
      req_rx[192 +: 64] = 64'h0000_0003_0033_3333;
      req_valid = 4'b1111;
      for (int c = 0; c < 40 && n_r < 4; c++) begin
         @(negedge clk);
         gmask = req_ready;
         if (req_ready !== 4'b0000) begin
            total++;
            if (req_ready !== 4'(1 << n_g)) begin
               bad++; $display("FAIL rr_grant%0d: got %b want %b", n_g, req_ready, 4'(1 << n_g));
            end
            n_g++;
         end
         if (resp_valid === 1'b1) begin
            total++;
            if ({resp_id, resp_data, resp_ok, resp_err} !== {2'(n_r), exp_d[n_r], 1'b0, 1'b0}) begin
               bad++; $display("FAIL rr_resp%0d: id=%0d data=%h ok=%b err=%b want %0d %h 0 0",
                               n_r, resp_id, resp_data, resp_ok, resp_err, n_r, exp_d[n_r]);
            end
            total++;
            if (c - last_r !== ((n_r == 0) ? 4 : 5)) begin
               bad++; $display("FAIL rr_spacing%0d: got %0d cycles want %0d", n_r, c - last_r,
                               (n_r == 0) ? 4 : 5);
            end
            last_r = c;
            n_r++;
         end
         tick();
         req_valid = req_valid & ~gmask;
      end
      total++;
      if (n_r !== 4) begin
         bad++; $display("FAIL rr_resp_count: got %0d want 4 within 40 cycles", n_r);
      end
      @(negedge clk);
      total++;
      if ({cnt_ok, cnt_fail, cnt_tmo} !== {16'd0, 16'd4, 16'd0}) begin
         bad++; $display("FAIL rr_counters: got %0d/%0d/%0d want 0/4/0", cnt_ok, cnt_fail, cnt_tmo);
      end
   endtask

   task automatic test_back_pressure;
      do_reset();
      resp_ready = 1'b0;
      req_rx[0   +: 64] = 64'h8000_0000_00AB_CDEF;
      req_rx[192 +: 64] = 64'h0000_0000_0000_0000;
      req_valid = 4'b1001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL bp_grant0: got %b want 0001", req_ready);
      end
      tick();
      req_valid = 4'b1000;
      repeat (3) tick();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if ({resp_valid, resp_id, resp_data, resp_ok, resp_err, req_ready, dec_start} !==
             {1'b1, 2'd0, 24'h0E684A, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL bp_hold%0d: rv=%b id=%0d data=%h ok=%b err=%b ready=%b start=%b", c,
                            resp_valid, resp_id, resp_data, resp_ok, resp_err, req_ready, dec_start);
         end
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({resp_valid, resp_data} !== {1'b1, 24'h0E684A}) begin
         bad++; $display("FAIL bp_accept: rv=%b data=%h want 1 0e684a", resp_valid, resp_data);
      end
      tick();
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, cnt_ok} !== {4'b1000, 1'b0, 16'd1}) begin
         bad++; $display("FAIL bp_next_grant: ready=%b rv=%b cnt_ok=%0d want 1000 0 1",
                         req_ready, resp_valid, cnt_ok);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if ({dec_start, dec_rx} !== {1'b1, 64'h0}) begin
         bad++; $display("FAIL bp_next_start: start=%b rx=%h", dec_start, dec_rx);
      end
      repeat (3) tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_data, resp_ok, resp_err} !== {1'b1, 2'd3, 24'hA5A5A5, 1'b0, 1'b0}) begin
         bad++; $display("FAIL bp_resp3: rv=%b id=%0d data=%h ok=%b err=%b want 1 3 a5a5a5 0 0",
                         resp_valid, resp_id, resp_data, resp_ok, resp_err);
      end
      tick();
      @(negedge clk);
      total++;
      if ({cnt_ok, cnt_fail, cnt_tmo} !== {16'd1, 16'd1, 16'd0}) begin
         bad++; $display("FAIL bp_counters: got %0d/%0d/%0d want 1/1/0", cnt_ok, cnt_fail, cnt_tmo);
      end
   endtask

   task automatic test_timeout;
      do_reset();
      stub_en = 1'b0;
      req_rx[64 +: 64] = 64'h8000_0000_0000_0001;
      req_valid = 4'b0010;
      @(negedge clk);
      tick();
      req_valid = '0;
      repeat (16) tick();
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin
         bad++; $display("FAIL tmo_early: rv=%b want 0 after 15 wait cycles", resp_valid);
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_data, resp_ok, resp_err} !== {1'b1, 2'd1, 24'h0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL tmo_resp: rv=%b id=%0d data=%h ok=%b err=%b want 1 1 000000 0 1",
                         resp_valid, resp_id, resp_data, resp_ok, resp_err);
      end
      stub_en = 1'b1;
      req_rx[128 +: 64] = 64'h0000_0000_00FF_FF00;
      req_valid = 4'b0100;
      tick();
      @(negedge clk);
      total++;
      if ({req_ready, cnt_ok, cnt_fail, cnt_tmo} !== {4'b0100, 16'd0, 16'd0, 16'd1}) begin
         bad++; $display("FAIL tmo_after: ready=%b cnt=%0d/%0d/%0d want 0100 0/0/1",
                         req_ready, cnt_ok, cnt_fail, cnt_tmo);
      end
      tick();
      req_valid = '0;
      repeat (3) tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_data, resp_ok, resp_err} !== {1'b1, 2'd2, 24'h5A5AA5, 1'b0, 1'b0}) begin
         bad++; $display("FAIL tmo_next_resp: rv=%b id=%0d data=%h ok=%b err=%b want 1 2 5a5aa5 0 0",
                         resp_valid, resp_id, resp_data, resp_ok, resp_err);
      end
      tick();
      @(negedge clk);
      total++;
      if ({cnt_ok, cnt_fail, cnt_tmo} !== {16'd0, 16'd1, 16'd1}) begin
         bad++; $display("FAIL tmo_counters: got %0d/%0d/%0d want 0/1/1", cnt_ok, cnt_fail, cnt_tmo);
      end
   endtask

   task automatic test_done_at_timeout;
      do_reset();
      lat = 16;
      req_rx[0 +: 64] = 64'h8000_0000_0000_0000;
      req_valid = 4'b0001;
      @(negedge clk);
      tick();
      req_valid = '0;
      repeat (16) tick();
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin
         bad++; $display("FAIL edge_early: rv=%b want 0", resp_valid);
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_id, resp_data, resp_ok, resp_err} !== {1'b1, 2'd0, 24'hA5A5A5, 1'b1, 1'b0}) begin
         bad++; $display("FAIL edge_resp: rv=%b id=%0d data=%h ok=%b err=%b want 1 0 a5a5a5 1 0",
                         resp_valid, resp_id, resp_data, resp_ok, resp_err);
      end
      tick();
      @(negedge clk);
      total++;
      if ({cnt_ok, cnt_fail, cnt_tmo} !== {16'd1, 16'd0, 16'd0}) begin
         bad++; $display("FAIL edge_counters: got %0d/%0d/%0d want 1/0/0", cnt_ok, cnt_fail, cnt_tmo);
      end
      lat = 2;
   endtask

   task automatic test_reset_mid_flight;
      do_reset();
      req_rx[0  +: 64] = 64'h8000_0000_0000_0010;
      req_rx[64 +: 64] = 64'h8000_0000_0000_0020;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (3) tick();
      @(negedge clk);
      total++;
      if ({resp_valid, resp_data, resp_ok} !== {1'b1, 24'hA5A5B5, 1'b1}) begin
         bad++; $display("FAIL mid_first_resp: rv=%b data=%h ok=%b want 1 a5a5b5 1",
                         resp_valid, resp_data, resp_ok);
      end
      stub_en = 1'b0;
      req_valid = 4'b0010;
      tick();
      @(negedge clk);
      total++;
      if ({req_ready, cnt_ok} !== {4'b0010, 16'd1}) begin
         bad++; $display("FAIL mid_second_grant: ready=%b cnt_ok=%0d want 0010 1", req_ready, cnt_ok);
      end
      tick();
      req_valid = '0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_err, dec_start, dec_rx,
           cnt_ok, cnt_fail, cnt_tmo} !== '0) begin
         bad++; $display("FAIL mid_reset_outputs: ready=%b rv=%b data=%h start=%b rx=%h cnt=%0d/%0d/%0d",
                         req_ready, resp_valid, resp_data, dec_start, dec_rx, cnt_ok, cnt_fail, cnt_tmo);
      end
      tick();
      force_done = 1'b1;
      @(negedge clk);
      tick();
      force_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if ({resp_valid, dec_start} !== 2'b00) begin
            bad++; $display("FAIL mid_stale_done%0d: rv=%b start=%b want 0 0", c, resp_valid, dec_start);
         end
         tick();
      end
      stub_en = 1'b1;
      req_valid = 4'b1001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL mid_ptr_reset: ready=%b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_rx     = '0;
      resp_ready = 1'b1;
      stub_en    = 1'b1;
      force_done = 1'b0;
      lat        = 2;
      test_reset();
      test_single();
      test_all_four();
      test_back_pressure();
      test_timeout();
      test_done_at_timeout();
      test_reset_mid_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/polar64_decode_sched.md
Name: polar64_decode_sched

Overview:
- Shares one polar64 CRC16 bounded-distance decoder instance between N_REQ requesters.
- Each requester offers a 64-bit received word on a valid/ready channel.
- The block arbitrates round-robin, sequences the decoder's start/done protocol and enforces a done-timeout.
- Each result is returned on a single tagged response channel, and per-outcome statistics are kept.
- Sits between the link-layer receive queues and the decoder.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles in WAIT before a job is declared timed out (>=13)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_rx  in  N_REQ*64  per-requester received word; slice i = bits [64*i+63:64*i]
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  $clog2(N_REQ)  requester index of the response
resp_data  out  24  decoded data
resp_ok  out  1  decoder reported a unique, CRC-passing codeword
resp_err  out  1  timeout; resp_data=0 and resp_ok=0 when set
dec_start  out  1  decoder start pulse
dec_rx  out  64  word to the decoder
dec_done  in  1  decoder done pulse
dec_data  in  24  decoder data_out
dec_valid  in  1  decoder valid
cnt_ok, cnt_fail, cnt_tmo  out  CNT_W each  saturating counts of responses with ok / not-ok-not-err / err

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including all counters.
  - Any in-flight job is discarded.
  - Decoder reset is separate and is driven by the top level.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, wrapping mod N_REQ.
  - In that same cycle assert req_ready[g]; the handshake completes combinationally on req_valid[g]&req_ready[g].
  - Latch rx into job_rx and g into job_id, then go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - dec_start=1 for exactly this cycle.
  - dec_rx=job_rx, held stable from ISSUE until leaving WAIT.
  - tmo_cnt cleared; go to WAIT.
- WAIT:
  - tmo_cnt increments each cycle.
  - On dec_done=1: capture dec_data/dec_valid into resp regs, err=0, go to RESP.
  - Else if tmo_cnt==TIMEOUT-1: data=0, ok=0, err=1, go to RESP.
  - If dec_done arrives in the same cycle the timeout is reached, dec_done wins.
- RESP:
  - resp_valid=1 with resp_id/data/ok/err stable until resp_ready=1.
  - On the accept cycle: increment exactly one counter (saturating at all-ones), set rr_ptr=(job_id+1) mod N_REQ, go to IDLE.
- dec_done outside WAIT is ignored.
- Timeout handling:
  - Timeout is a fault path only; the decoder guarantees done within 12 cycles.
  - No drain is performed. A late done from a timed-out job may be misattributed to the next job; this is accepted and reported by the bench.
- Latency:
  - Grant to resp_valid is 2 + (decoder done latency) cycles. With the current decoder (done at start+2) this is 4 cycles.
  - Minimum job period is 5 cycles with resp_ready tied high.
- Fairness: a requester holding req_valid is granted within N_REQ jobs.
- Requester-side requirement: req_valid/req_rx must be held stable until accepted. Not checked.

Decomposition:
- Package polar64_pkg holds:
  - state enum sched_state_t {IDLE, ISSUE, WAIT, RESP}.
  - struct dec_resp_t {id, data[23:0], ok, err}.
  - Constant DEC_MAX_LAT=12.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot grant, index, any.
  - Purely combinational.
- The FSM, timeout counter and statistics counters stay in polar64_decode_sched.

Test Plan:
All scenarios use a decoder stub: done at start+2, dec_data=rx[23:0]^24'hA5A5A5, dec_valid=rx[63].

1. Single request, requester 2, rx=64'h8000_0000_0012_3456, resp_ready=1:
   - req_ready[2] pulses in cycle 0; dec_start in cycle 1.
   - resp_valid in cycle 4 with id=2, data=24'hB791F3, ok=1, err=0.
   - cnt_ok=1.
2. All four requesters valid at once, rx MSB=0 for all:
   - Grants in order 0,1,2,3; ids returned in order 0,1,2,3.
   - Each response has ok=0; cnt_fail=4.
   - Responses 5 cycles apart.
3. Backpressure: resp_ready=0 for 10 cycles, then 1:
   - resp_* held stable throughout.
   - No second req_ready and no second dec_start until accept.
4. Stub never asserts done:
   - resp_valid in the cycle after TIMEOUT WAIT cycles, with err=1, ok=0, data=0; cnt_tmo=1.
   - Next job proceeds normally.
5. Stub asserts done in the exact cycle tmo_cnt==TIMEOUT-1 (stub latency 16):
   - err=0 and data taken from the decoder.
6. Reset mid-flight:
   - rst=1 for one cycle during WAIT → next cycle all outputs 0, state IDLE, counters 0.
   - A stale dec_done two cycles later produces no response.
